// File: rtl/fir_root_pkg.sv
// Shared types and constants for the FIR+ROOT coefficient/stream controller.
package fir_root_pkg;

  localparam int NUM_TAPS = 7;
  localparam int COEF_W   = 8;
  localparam int DCNT_W   = 6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

  // Saturating increment keeps the drain counter from wrapping in a long drain.
  function automatic logic [DCNT_W-1:0] sat_inc(input logic [DCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fir_root_vld_pipe.sv
// Valid delay line tracking accepted samples through the external datapath.
module fir_root_vld_pipe #(
  parameter int PIPE_LAT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_in,
  output logic vld_out,
  output logic vld_any
);

  logic [PIPE_LAT-1:0] vld_q, vld_d;

  always_comb begin
    vld_d = {vld_q[PIPE_LAT-2:0], vld_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  assign vld_out = vld_q[PIPE_LAT-1];
  assign vld_any = |vld_q;

endmodule

// File: rtl/fir_root_ctrl.sv
// Stream gate plus shadow/active coefficient swap for a FIR+ROOT datapath;
// a commit blocks input, flushes the pipe with zeros, then swaps coefficients.
module fir_root_ctrl
  import fir_root_pkg::*;
#(
  parameter int PIPE_LAT = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        cfg_commit,
  output logic        cfg_busy,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  dp_data,
  output logic [7:0]  dp_b0,
  output logic [7:0]  dp_b1,
  output logic [7:0]  dp_b2,
  output logic [7:0]  dp_b3,
  output logic [7:0]  dp_b4,
  output logic [7:0]  dp_b5,
  output logic [7:0]  dp_b6,
  output logic        out_valid,
  output logic [15:0] out_cnt
);

  localparam logic [DCNT_W-1:0] LAT_CNT = DCNT_W'(PIPE_LAT);

  state_e                             state_q, state_d;
  logic                               pending_q, pending_d;
  logic [NUM_TAPS-1:0][COEF_W-1:0]    shadow_q, shadow_d;
  logic [NUM_TAPS-1:0][COEF_W-1:0]    active_q, active_d;
  logic [COEF_W-1:0]                  dp_data_q, dp_data_d;
  logic [DCNT_W-1:0]                  drain_cnt_q, drain_cnt_d;
  logic [15:0]                        out_cnt_q, out_cnt_d;
  logic                               accept;
  logic                               vld_out;
  logic                               vld_any;

  assign in_ready = (state_q == ST_RUN) && !pending_q;
  assign accept   = in_valid && in_ready;
  assign cfg_busy = pending_q || (state_q != ST_RUN);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    drain_cnt_d = drain_cnt_q;
    dp_data_d   = accept ? in_data : '0;
    out_cnt_d   = out_cnt_q + 16'(vld_out);

    for (int t = 0; t < NUM_TAPS; t++) begin
      if (cfg_we && (cfg_addr == 3'(t))) shadow_d[t] = cfg_wdata;
    end

    case (state_q)
      ST_RUN: begin
        if (pending_q) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // drain_cnt_d counts DRAIN cycles including this one
        drain_cnt_d = sat_inc(drain_cnt_q);
        if ((drain_cnt_d >= LAT_CNT) && !vld_any) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        // registered shadow, so a same-cycle write is not swapped in
        active_d  = shadow_q;
        pending_d = 1'b0;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (cfg_commit) pending_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_RUN;
      pending_q   <= 1'b0;
      shadow_q    <= '0;
      active_q    <= '0;
      dp_data_q   <= '0;
      drain_cnt_q <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      dp_data_q   <= dp_data_d;
      drain_cnt_q <= drain_cnt_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  fir_root_vld_pipe #(.PIPE_LAT(PIPE_LAT)) u_vld_pipe (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .vld_in  (accept),
    .vld_out (vld_out),
    .vld_any (vld_any)
  );

  assign out_valid = vld_out;
  assign out_cnt   = out_cnt_q;
  assign dp_data   = dp_data_q;
  assign dp_b0     = active_q[0];
  assign dp_b1     = active_q[1];
  assign dp_b2     = active_q[2];
  assign dp_b3     = active_q[3];
  assign dp_b4     = active_q[4];
  assign dp_b5     = active_q[5];
  assign dp_b6     = active_q[6];

endmodule

// File: tb/tb_fir_root_ctrl.sv
// Directed bench for fir_root_ctrl with PIPE_LAT=8 and hand-computed expectations.
module tb_fir_root_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic        cfg_commit = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        cfg_busy, in_ready, out_valid;
  logic [7:0]  dp_data, dp_b0, dp_b1, dp_b2, dp_b3, dp_b4, dp_b5, dp_b6;
  logic [15:0] out_cnt;
  wire  [55:0] dp_all = {dp_b6, dp_b5, dp_b4, dp_b3, dp_b2, dp_b1, dp_b0};

  int errors = 0;
  int checks = 0;

  fir_root_ctrl #(.PIPE_LAT(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dp_data(dp_data),
    .dp_b0(dp_b0), .dp_b1(dp_b1), .dp_b2(dp_b2), .dp_b3(dp_b3),
    .dp_b4(dp_b4), .dp_b5(dp_b5), .dp_b6(dp_b6),
    .out_valid(out_valid), .out_cnt(out_cnt)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, first, last, nov;

    // reset state
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_dp_data", dp_data, 0);
    chk("rst_taps", dp_all, 0);
    Rst_n = 1'b1;
    tick();

    // shadow = 1..7, index 7 ignored, commit -> 1 RUN + 8 DRAIN + SWAP
    for (int i = 0; i < 7; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_wdata = 8'(i + 1);
      tick();
    end
    cfg_addr = 3'd7; cfg_wdata = 8'hEE;
    tick();
    cfg_we = 1'b0;
    chk("active_hold", dp_all, 0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("commit_ready", in_ready, 0);
    chk("commit_busy", cfg_busy, 1);
    n = 0;
    while (dp_b0 !== 8'd1 && n < 40) begin tick(); n++; end
    chk("swap_lat", n, 10);
    chk("swap_taps", dp_all, 56'h07060504030201);
    chk("swap_busy", cfg_busy, 0);
    chk("swap_ready", in_ready, 1);

    // 20 back-to-back samples
    first = -1; last = -1; nov = 0;
    in_valid = 1'b1; in_data = 8'h10;
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (j < 20) in_data = 8'(8'h10 + j);
      else        in_valid = 1'b0;
      if (j == 1) chk("dp_data_first", dp_data, 8'h10);
      if (out_valid) begin
        if (first < 0) first = j;
        last = j;
        nov++;
      end
    end
    chk("ov_first", first, 8);
    chk("ov_last", last, 27);
    chk("ov_count", nov, 20);
    chk("stream_cnt20", out_cnt, 20);
    chk("dp_data_zero", dp_data, 0);

    // commit during a continuous stream
    in_valid = 1'b1; in_data = 8'h20;
    repeat (5) tick();
    chk("pre_commit_ready", in_ready, 1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("blk_ready", in_ready, 0);
    chk("blk_busy", cfg_busy, 1);
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
    in_valid = 1'b0;
    chk("drain_len", n, 10);
    nov = 0;
    repeat (12) begin tick(); if (out_valid) nov++; end
    chk("post_swap_ov", nov, 0);
    chk("stream_cnt26", out_cnt, 26);

    // commit + tap3 write landing in the SWAP cycle
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    repeat (9) tick();
    chk("swap_cyc_busy", cfg_busy, 1);
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 8'h55; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("tap3_old", dp_b3, 8'd4);
    chk("repend_busy", cfg_busy, 1);
    chk("repend_ready", in_ready, 0);
    n = 0;
    while (dp_b3 !== 8'h55 && n < 40) begin tick(); n++; end
    chk("second_drain_len", n, 10);
    chk("tap3_new", dp_all, 56'h07060555030201);
    chk("second_busy", cfg_busy, 0);

    // reset pulse mid-DRAIN with a sample in flight
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'h99;
    tick();
    cfg_we = 1'b0;
    in_valid = 1'b1; in_data = 8'h33; cfg_commit = 1'b1;
    tick();
    in_valid = 1'b0; cfg_commit = 1'b0;
    repeat (4) tick();
    chk("mid_drain_busy", cfg_busy, 1);
    Rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", cfg_busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_cnt", out_cnt, 0);
    chk("arst_dp_data", dp_data, 0);
    chk("arst_taps", dp_all, 0);
    #2;
    Rst_n = 1'b1;
    nov = 0;
    repeat (15) begin tick(); if (out_valid) nov++; end
    chk("post_rst_ov", nov, 0);
    chk("post_rst_busy", cfg_busy, 0);
    chk("post_rst_cnt", out_cnt, 0);
    chk("post_rst_taps", dp_all, 0);

    // out_cnt wrap from 0xFFFE
    force dut.out_cnt_q = 16'hFFFE;
    tick();
    release dut.out_cnt_q;
    chk("preload_cnt", out_cnt, 16'hFFFE);
    in_valid = 1'b1; in_data = 8'h44;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (12) tick();
    chk("wrap_cnt", out_cnt, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
